// File: rtl/split_n_buf_if.sv
// Handshake bundle for split_n_buf: joined data/control inputs and NUM_OUT buffered outputs.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface split_n_buf_if #(
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned SEL_W   = $clog2(NUM_OUT + 1)
);
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         ctl_sel;
  logic                     ctl_valid;
  logic                     ctl_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output ctl_sel,
    output ctl_valid,
    input  ctl_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  ctl_sel,
    input  ctl_valid,
    output ctl_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/split_n_buf.sv
// N-way buffered split: joins data and control tokens and routes data into per-channel FIFOs.
// Optional broadcast on ctl_sel == NUM_OUT when SPLIT_N_BUF_BCAST_EN is defined.
module split_n_buf #(
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  split_n_buf_if.slave bus,
  output logic         drop_err,
  output logic [7:0]   drop_cnt
);
  localparam int unsigned SEL_W = $clog2(NUM_OUT + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} chan_st_e;

  logic [WIDTH-1:0] mem_q    [NUM_OUT][DEPTH];
  logic [CNT_W-1:0] count_q  [NUM_OUT];
  logic [CNT_W-1:0] count_d  [NUM_OUT];
  logic [PTR_W-1:0] rd_ptr_q [NUM_OUT];
  logic [PTR_W-1:0] wr_ptr_q [NUM_OUT];
  chan_st_e         st_q     [NUM_OUT];
  chan_st_e         st_d     [NUM_OUT];

  logic [NUM_OUT-1:0] not_full;
  logic [NUM_OUT-1:0] sel_hit;
  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;
  logic [NUM_OUT-1:0] chan_valid;
  logic               room;
  logic               discard;
  logic               fire;
  logic               drop;
  logic               drop_err_q;
  logic [7:0]         drop_cnt_q;

  // Fullness comes from the registered count only, so a pop never frees space in the same cycle.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      not_full[k]   = (count_q[k] < CNT_W'(DEPTH));
      chan_valid[k] = (st_q[k] != StEmpty);
    end
  end

  always_comb begin
    sel_hit = '0;
    room    = 1'b0;
    discard = 1'b0;
    if (bus.ctl_sel < SEL_W'(NUM_OUT)) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        sel_hit[k] = (bus.ctl_sel == SEL_W'(k));
      end
      room = |(sel_hit & not_full);
`ifdef SPLIT_N_BUF_BCAST_EN
    end else if (bus.ctl_sel == SEL_W'(NUM_OUT)) begin
      sel_hit = '1;
      room    = &not_full;
`endif
    end else begin
      room    = 1'b1;
      discard = 1'b1;
    end
  end

  assign fire          = rst_n & bus.in_valid & bus.ctl_valid & room;
  assign bus.in_ready  = fire;
  assign bus.ctl_ready = fire;
  assign push          = fire ? sel_hit : '0;
  assign drop          = fire & discard;
  assign pop           = chan_valid & bus.out_ready;

  // Per-channel occupancy and state; the state always tracks the count band.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      count_d[k] = count_q[k];
      st_d[k]    = st_q[k];
      unique case ({push[k], pop[k]})
        2'b10:   count_d[k] = count_q[k] + CNT_W'(1);
        2'b01:   count_d[k] = count_q[k] - CNT_W'(1);
        default: count_d[k] = count_q[k];
      endcase
      unique case (st_q[k])
        StEmpty: begin
          if (push[k]) st_d[k] = StPartial;
        end
        StPartial: begin
          if (push[k] && !pop[k] && (count_q[k] == CNT_W'(DEPTH - 1))) begin
            st_d[k] = StFull;
          end else if (pop[k] && !push[k] && (count_q[k] == CNT_W'(1))) begin
            st_d[k] = StEmpty;
          end
        end
        StFull: begin
          if (pop[k]) st_d[k] = StPartial;
        end
        default: st_d[k] = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        count_q[k]  <= '0;
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        st_q[k]     <= StEmpty;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[k][d] <= '0;
        end
      end
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        count_q[k] <= count_d[k];
        st_q[k]    <= st_d[k];
        if (push[k]) begin
          mem_q[k][wr_ptr_q[k]] <= bus.in_data;
          wr_ptr_q[k]           <= wr_ptr_q[k] + PTR_W'(1);
        end
        if (pop[k]) begin
          rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
        end
      end
      drop_err_q <= drop;
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = mem_q[k][rd_ptr_q[k]];
    end
  end

  assign bus.out_valid = chan_valid;
  assign drop_err      = drop_err_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_split_n_buf.sv
// Directed bench for split_n_buf with hand-computed expectations (WIDTH 11, NUM_OUT 4, DEPTH 2).
// Follows SPLIT_N_BUF_BCAST_EN to pick the drop code and the broadcast scenario.
module tb_split_n_buf;
  localparam int unsigned WIDTH   = 11;
  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned SEL_W   = 3;
`ifdef SPLIT_N_BUF_BCAST_EN
  localparam logic [SEL_W-1:0] DropSel = 3'd5;
`else
  localparam logic [SEL_W-1:0] DropSel = 3'd4;
`endif

  logic       clk;
  logic       rst_n;
  logic       drop_err;
  logic [7:0] drop_cnt;
  int         n_checks;
  int         n_errors;

  split_n_buf_if #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) bus ();

  split_n_buf #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drop_err (drop_err),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active edge, then return at the following falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s, input logic v);
    bus.in_data   = d;
    bus.ctl_sel   = s;
    bus.in_valid  = v;
    bus.ctl_valid = v;
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.ctl_valid = 1'b0;
    #1;
  endtask

  function automatic logic [WIDTH-1:0] chan(input int k);
    return bus.out_data[k*WIDTH +: WIDTH];
  endfunction

  int   pulses;
  int   stray;
  int   stalls;
  logic [NUM_OUT-1:0] ov_seen;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.ctl_sel   = '0;
    bus.in_valid  = 1'b1;
    bus.ctl_valid = 1'b1;
    bus.out_ready = '0;
    step();
    step();
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_ctl_ready", {63'd0, bus.ctl_ready}, 64'd0);
    check("rst_out_valid", {60'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", {20'd0, bus.out_data}, 64'd0);
    check("rst_drop", {55'd0, drop_err, drop_cnt}, 64'd0);
    idle();
    rst_n = 1'b1;
    step();

    // Routing and one-cycle latency.
    bus.out_ready = 4'hF;
    drive(11'h155, 3'd2, 1'b1);
    check("t1_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("t1_ctl_ready", {63'd0, bus.ctl_ready}, 64'd1);
    step();
    idle();
    check("t1_out_valid", {60'd0, bus.out_valid}, 64'h4);
    check("t1_out_data2", {53'd0, chan(2)}, 64'h155);
    step();
    check("t1_drained", {60'd0, bus.out_valid}, 64'h0);

    // Backpressure on channel 1; input stays in order.
    bus.out_ready = 4'b1101;
    drive(11'h001, 3'd1, 1'b1);
    check("t2_fire1", {63'd0, bus.in_ready}, 64'd1);
    step();
    drive(11'h002, 3'd1, 1'b1);
    check("t2_fire2", {63'd0, bus.in_ready}, 64'd1);
    step();
    drive(11'h003, 3'd1, 1'b1);
    check("t2_stall", {63'd0, bus.in_ready}, 64'd0);
    step();
    check("t2_stall_hold", {62'd0, bus.ctl_ready, bus.in_ready}, 64'd0);
    check("t2_ov_full", {60'd0, bus.out_valid}, 64'h2);
    check("t2_head_hold", {53'd0, chan(1)}, 64'h001);
    bus.out_ready = 4'hF;
    #1;
    check("t2_no_passthru", {63'd0, bus.in_ready}, 64'd0);
    step();
    check("t2_order2", {53'd0, chan(1)}, 64'h002);
    check("t2_fire3", {63'd0, bus.in_ready}, 64'd1);
    step();
    drive(11'h0AA, 3'd0, 1'b1);
    check("t2_order3", {53'd0, chan(1)}, 64'h003);
    check("t2_fire_aa", {63'd0, bus.in_ready}, 64'd1);
    step();
    idle();
    check("t2_ov_aa", {60'd0, bus.out_valid}, 64'h1);
    check("t2_data_aa", {53'd0, chan(0)}, 64'h0AA);
    step();
    check("t2_drained", {60'd0, bus.out_valid}, 64'h0);

    // Full FIFO popped in the same cycle still refuses the push.
    bus.out_ready = 4'b0111;
    drive(11'h011, 3'd3, 1'b1);
    step();
    drive(11'h022, 3'd3, 1'b1);
    step();
    drive(11'h033, 3'd3, 1'b1);
    check("t3_full_stall", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 4'hF;
    #1;
    check("t3_pop_cycle", {63'd0, bus.in_ready}, 64'd0);
    step();
    check("t3_fire_after", {63'd0, bus.in_ready}, 64'd1);
    check("t3_head2", {53'd0, chan(3)}, 64'h022);
    step();
    idle();
    check("t3_ov", {60'd0, bus.out_valid}, 64'h8);
    check("t3_head3", {53'd0, chan(3)}, 64'h033);
    step();
    check("t3_drained", {60'd0, bus.out_valid}, 64'h0);

    // Drops: one pulse per discarded pair, counter saturates.
    pulses  = 0;
    stray   = 0;
    stalls  = 0;
    ov_seen = '0;
    for (int i = 0; i < 300; i++) begin
      drive(11'h7FF, DropSel, 1'b1);
      if (bus.in_ready !== 1'b1) stalls++;
      step();
      idle();
      if (drop_err === 1'b1) pulses++;
      ov_seen = ov_seen | bus.out_valid;
      if (i == 9) check("t4_cnt10", {56'd0, drop_cnt}, 64'd10);
      step();
      if (drop_err !== 1'b0) stray++;
      ov_seen = ov_seen | bus.out_valid;
    end
    check("t4_stalls", 64'(stalls), 64'd0);
    check("t4_pulses", 64'(pulses), 64'd300);
    check("t4_pulse_len", 64'(stray), 64'd0);
    check("t4_no_out", {60'd0, ov_seen}, 64'h0);
    check("t4_sat", {56'd0, drop_cnt}, 64'd255);

    // Join skew: control arrives three cycles early.
    bus.in_data   = 11'h05A;
    bus.ctl_sel   = 3'd0;
    bus.ctl_valid = 1'b1;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_ctl_wait", {62'd0, bus.ctl_ready, bus.in_ready}, 64'd0);
      step();
    end
    bus.in_valid = 1'b1;
    #1;
    check("t5_fire", {62'd0, bus.ctl_ready, bus.in_ready}, 64'd3);
    step();
    idle();
    check("t5_ov", {60'd0, bus.out_valid}, 64'h1);
    check("t5_data", {53'd0, chan(0)}, 64'h05A);
    step();
    check("t5_single", {60'd0, bus.out_valid}, 64'h0);

    // Reset with tokens buffered.
    bus.out_ready = 4'h0;
    drive(11'h0B1, 3'd0, 1'b1);
    step();
    drive(11'h0B2, 3'd2, 1'b1);
    step();
    idle();
    check("t6_buffered", {60'd0, bus.out_valid}, 64'h5);
    rst_n = 1'b0;
    step();
    check("t6_rst_ov", {60'd0, bus.out_valid}, 64'h0);
    check("t6_rst_data", {20'd0, bus.out_data}, 64'd0);
    check("t6_rst_cnt", {55'd0, drop_err, drop_cnt}, 64'd0);
    rst_n         = 1'b1;
    bus.out_ready = 4'hF;
    step();
    step();
    check("t6_no_stale", {60'd0, bus.out_valid}, 64'h0);

    bus.out_ready = 4'h0;
    drive(11'h123, 3'd4, 1'b1);
    check("t6_sel4_fire", {63'd0, bus.in_ready}, 64'd1);
    step();
    idle();
`ifdef SPLIT_N_BUF_BCAST_EN
    check("t6_bcast_ov", {60'd0, bus.out_valid}, 64'hF);
    check("t6_bcast_data", {20'd0, bus.out_data}, {20'd0, {4{11'h123}}});
    check("t6_bcast_nodrop", {55'd0, drop_err, drop_cnt}, 64'd0);
`else
    check("t6_sel4_ov", {60'd0, bus.out_valid}, 64'h0);
    check("t6_sel4_drop", {55'd0, drop_err, drop_cnt}, {55'd0, 1'b1, 8'd1});
`endif
    bus.out_ready = 4'hF;
    step();
    check("t6_final_empty", {60'd0, bus.out_valid}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
